stall_unit: RTL and testbench

Hazard-detection and interlock block for the five-stage MIPS pipeline. It detects the dependences that the forwarding network cannot resolve: load-use, branch/jr operands still in flight, and HI/LO access while the multiply/divide unit is busy. For each one it holds PC and IF/ID and injects a bubble into ID/EX. It also owns the mult/div busy counter and a saturating stall-cycle performance counter.

---
 rtl/stall_unit.sv | 104 ++++++++++
 tb/tb_stall_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_unit.sv
// Hazard detection and interlock for the five-stage MIPS pipeline: load-use,
// branch/jr operand interlocks, mult/div busy tracking and a stall-cycle counter.
module stall_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_if_id,
    input  logic [4:0]  rt_if_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic        Branch,
    input  logic        jr_id,
    input  logic        md_id,
    input  logic        RegWrite_id_ex,
    input  logic        MemRead_id_ex,
    input  logic [4:0]  WReg_id_ex,
    input  logic        MemRead_ex_mem,
    input  logic [4:0]  WReg_ex_mem,
    input  logic        start_mult_ex,
    input  logic        start_div_ex,
    input  logic        stat_clr,
    output logic        stall,
    output logic        flush_id_ex,
    output logic        busy,
    output logic [3:0]  busy_cnt,
    output logic [31:0] stall_count
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]  busy_cnt_reg;
    logic [31:0] stall_count_reg;

    logic ex_wreg_valid;
    logic mem_wreg_valid;
    logic ex_match_rs;
    logic ex_match_rt;
    logic mem_match_rs;
    logic mem_match_rt;
    logic id_reads_early;
    logic hz_load_use;
    logic hz_branch_ex;
    logic hz_branch_mem;
    logic hz_md;
    logic stall_any;

    // Register $0 is never a real dependence, so a zero destination cannot match.
    assign ex_wreg_valid  = (WReg_id_ex != 5'd0);
    assign mem_wreg_valid = (WReg_ex_mem != 5'd0);
    assign ex_match_rs    = ex_wreg_valid && (WReg_id_ex == rs_if_id);
    assign ex_match_rt    = ex_wreg_valid && (WReg_id_ex == rt_if_id);
    assign mem_match_rs   = mem_wreg_valid && (WReg_ex_mem == rs_if_id);
    assign mem_match_rt   = mem_wreg_valid && (WReg_ex_mem == rt_if_id);

    assign id_reads_early = Branch || jr_id;

    assign hz_load_use = MemRead_id_ex && RegWrite_id_ex &&
                         ((use_rs_id && ex_match_rs) || (use_rt_id && ex_match_rt));

    // jr/jalr only reads rs; branches compare rs against rt in ID.
    assign hz_branch_ex = id_reads_early && RegWrite_id_ex &&
                          (ex_match_rs || (Branch && ex_match_rt));

    assign hz_branch_mem = id_reads_early && MemRead_ex_mem &&
                           (mem_match_rs || (Branch && mem_match_rt));

    assign hz_md = md_id && (busy || start_mult_ex || start_div_ex);

    assign stall_any   = hz_load_use || hz_branch_ex || hz_branch_mem || hz_md;
    assign stall       = stall_any && !reset;
    assign flush_id_ex = stall_any && !reset;

    // A start reloads even when already busy; div wins over a simultaneous mult.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt_reg <= 4'd0;
        end else if (start_div_ex) begin
            busy_cnt_reg <= DIV_LOAD;
        end else if (start_mult_ex) begin
            busy_cnt_reg <= MULT_LOAD;
        end else if (busy_cnt_reg != 4'd0) begin
            busy_cnt_reg <= busy_cnt_reg - 4'd1;
        end
    end

    assign busy_cnt = busy_cnt_reg;
    assign busy     = (busy_cnt_reg != 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_reg <= 32'd0;
        end else if (stat_clr) begin
            stall_count_reg <= 32'd0;
        end else if (stall && !(&stall_count_reg)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_stall_unit.sv
// Scenario-driven bench for stall_unit: expectations are queued as each step is
// driven and popped for comparison just after the combinational settle point.
module tb_stall_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_if_id;
    logic [4:0]  rt_if_id;
    logic        use_rs_id;
    logic        use_rt_id;
    logic        Branch;
    logic        jr_id;
    logic        md_id;
    logic        RegWrite_id_ex;
    logic        MemRead_id_ex;
    logic [4:0]  WReg_id_ex;
    logic        MemRead_ex_mem;
    logic [4:0]  WReg_ex_mem;
    logic        start_mult_ex;
    logic        start_div_ex;
    logic        stat_clr;
    logic        stall;
    logic        flush_id_ex;
    logic        busy;
    logic [3:0]  busy_cnt;
    logic [31:0] stall_count;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       br;
        logic       jr;
        logic       md;
        logic       rw_ex;
        logic       mr_ex;
        logic [4:0] wreg_ex;
        logic       mr_mem;
        logic [4:0] wreg_mem;
        logic       smul;
        logic       sdiv;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic [3:0]  cnt;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];

    stall_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .Branch(Branch), .jr_id(jr_id), .md_id(md_id),
        .RegWrite_id_ex(RegWrite_id_ex), .MemRead_id_ex(MemRead_id_ex),
        .WReg_id_ex(WReg_id_ex),
        .MemRead_ex_mem(MemRead_ex_mem), .WReg_ex_mem(WReg_ex_mem),
        .start_mult_ex(start_mult_ex), .start_div_ex(start_div_ex),
        .stat_clr(stat_clr),
        .stall(stall), .flush_id_ex(flush_id_ex),
        .busy(busy), .busy_cnt(busy_cnt), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t load_ex(input logic [4:0] w);
        stim_t s;
        s = '0;
        s.rw_ex = 1'b1;
        s.mr_ex = 1'b1;
        s.wreg_ex = w;
        return s;
    endfunction

    function automatic exp_t mk(input logic st, input logic [3:0] c, input logic [31:0] sc);
        exp_t e;
        e.stall = st;
        e.cnt = c;
        e.sc = sc;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rs_if_id = s.rs;
        rt_if_id = s.rt;
        use_rs_id = s.use_rs;
        use_rt_id = s.use_rt;
        Branch = s.br;
        jr_id = s.jr;
        md_id = s.md;
        RegWrite_id_ex = s.rw_ex;
        MemRead_id_ex = s.mr_ex;
        WReg_id_ex = s.wreg_ex;
        MemRead_ex_mem = s.mr_mem;
        WReg_ex_mem = s.wreg_mem;
        start_mult_ex = s.smul;
        start_div_ex = s.sdiv;
        stat_clr = s.clr;
    endtask

    // Drive one pipeline cycle's inputs after the falling edge and queue its expectation.
    task automatic drive(input stim_t s, input exp_t e);
        @(negedge clk);
        apply(s);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply(idle());
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        stim_t s;
        s = load_ex(5'd8);
        s.use_rs = 1'b1;
        s.rs = 5'd8;
        s.sdiv = 1'b1;
        s.md = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        apply(s);
        #1;
        tests_run++;
        if ({stall, flush_id_ex, busy, busy_cnt, stall_count} !== {1'b0, 1'b0, 1'b0, 4'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_hold: stall=%0b flush=%0b busy=%0b cnt=%0d sc=%0d required all 0",
                     stall, flush_id_ex, busy, busy_cnt, stall_count);
        end else $display("[TB] reset_hold ok");
        @(posedge clk);
        #1;
        tests_run++;
        if ({busy, busy_cnt, stall_count} !== {1'b0, 4'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_edge: busy=%0b cnt=%0d sc=%0d required 0", busy, busy_cnt, stall_count);
        end else $display("[TB] reset_edge ok");
        apply(idle());
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        stim_t st[$];
        exp_t  e;
        stim_t s;
        do_reset();
        s = load_ex(5'd8); s.use_rs = 1'b1; s.rs = 5'd8;              st.push_back(s);
        s = idle(); s.mr_mem = 1'b1; s.wreg_mem = 5'd8; s.use_rs = 1'b1; s.rs = 5'd8; st.push_back(s);
        s = load_ex(5'd8); s.use_rt = 1'b1; s.rt = 5'd8; s.use_rs = 1'b1; s.rs = 5'd3; st.push_back(s);
        s = load_ex(5'd0); s.use_rs = 1'b1; s.rs = 5'd0;              st.push_back(s);
        s = load_ex(5'd8); s.rs = 5'd8;                               st.push_back(s);
        s = idle(); s.rw_ex = 1'b1; s.wreg_ex = 5'd8; s.use_rs = 1'b1; s.rs = 5'd8; st.push_back(s);
        for (int i = 0; i < st.size(); i++) begin
            case (i)
                0: drive(st[i], mk(1'b1, 4'd0, 32'd0));
                1: drive(st[i], mk(1'b0, 4'd0, 32'd1));
                2: drive(st[i], mk(1'b1, 4'd0, 32'd1));
                default: drive(st[i], mk(1'b0, 4'd0, 32'd2));
            endcase
            e = exp_q.pop_front();
            tests_run++;
            if ({stall, flush_id_ex, busy_cnt, stall_count} !== {e.stall, e.stall, e.cnt, e.sc}) begin
                tests_failed++;
                $display("FAIL load_use step %0d: stall=%0b flush=%0b cnt=%0d sc=%0d required stall=%0b cnt=%0d sc=%0d",
                         i, stall, flush_id_ex, busy_cnt, stall_count, e.stall, e.cnt, e.sc);
            end else $display("[TB] load_use step %0d ok stall=%0b sc=%0d", i, stall, stall_count);
        end
    endtask

    task automatic test_branch();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        stim_t s;
        do_reset();
        s = load_ex(5'd9); s.br = 1'b1; s.rs = 5'd9;                          st.push_back(s); ex.push_back(mk(1'b1, 4'd0, 32'd0));
        s = idle(); s.mr_mem = 1'b1; s.wreg_mem = 5'd9; s.br = 1'b1; s.rs = 5'd9; st.push_back(s); ex.push_back(mk(1'b1, 4'd0, 32'd1));
        s = idle(); s.br = 1'b1; s.rs = 5'd9;                                 st.push_back(s); ex.push_back(mk(1'b0, 4'd0, 32'd2));
        s = idle(); s.rw_ex = 1'b1; s.wreg_ex = 5'd9; s.jr = 1'b1; s.rs = 5'd9; st.push_back(s); ex.push_back(mk(1'b1, 4'd0, 32'd2));
        s = idle(); s.wreg_mem = 5'd9; s.jr = 1'b1; s.rs = 5'd9;              st.push_back(s); ex.push_back(mk(1'b0, 4'd0, 32'd3));
        s = idle(); s.rw_ex = 1'b1; s.wreg_ex = 5'd9; s.jr = 1'b1; s.rs = 5'd4; s.rt = 5'd9; st.push_back(s); ex.push_back(mk(1'b0, 4'd0, 32'd3));
        s = idle(); s.rw_ex = 1'b1; s.wreg_ex = 5'd9; s.br = 1'b1; s.rs = 5'd4; s.rt = 5'd9; st.push_back(s); ex.push_back(mk(1'b1, 4'd0, 32'd3));
        s = idle(); s.mr_mem = 1'b1; s.wreg_mem = 5'd9; s.br = 1'b1; s.rs = 5'd4; s.rt = 5'd9; st.push_back(s); ex.push_back(mk(1'b1, 4'd0, 32'd4));
        s = idle(); s.mr_mem = 1'b1; s.wreg_mem = 5'd9; s.jr = 1'b1; s.rs = 5'd4; s.rt = 5'd9; st.push_back(s); ex.push_back(mk(1'b0, 4'd0, 32'd5));
        s = idle(); s.rw_ex = 1'b1; s.wreg_ex = 5'd0; s.br = 1'b1;            st.push_back(s); ex.push_back(mk(1'b0, 4'd0, 32'd5));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            e = exp_q.pop_front();
            tests_run++;
            if ({stall, flush_id_ex, stall_count} !== {e.stall, e.stall, e.sc}) begin
                tests_failed++;
                $display("FAIL branch step %0d: stall=%0b flush=%0b sc=%0d required stall=%0b sc=%0d",
                         i, stall, flush_id_ex, stall_count, e.stall, e.sc);
            end else $display("[TB] branch step %0d ok stall=%0b sc=%0d", i, stall, stall_count);
        end
    endtask

    // mflo held in ID from the start cycle; busy counts n..1 then releases.
    task automatic test_md(input bit is_div);
        stim_t s;
        exp_t  e;
        int    n;
        n = is_div ? 10 : 5;
        do_reset();
        for (int i = 0; i <= n + 2; i++) begin
            s = idle();
            s.md = 1'b1;
            if (i == 0) begin
                s.smul = !is_div;
                s.sdiv = is_div;
                drive(s, mk(1'b1, 4'd0, 32'd0));
            end else if (i <= n) begin
                drive(s, mk(1'b1, 4'(n + 1 - i), 32'(i)));
            end else begin
                drive(s, mk(1'b0, 4'd0, 32'(n + 1)));
            end
            e = exp_q.pop_front();
            tests_run++;
            if ({stall, flush_id_ex, busy, busy_cnt, stall_count} !== {e.stall, e.stall, e.cnt != 4'd0, e.cnt, e.sc}) begin
                tests_failed++;
                $display("FAIL md_%s step %0d: stall=%0b busy=%0b cnt=%0d sc=%0d required stall=%0b cnt=%0d sc=%0d",
                         is_div ? "div" : "mult", i, stall, busy, busy_cnt, stall_count, e.stall, e.cnt, e.sc);
            end else $display("[TB] md_%s step %0d ok cnt=%0d stall=%0b", is_div ? "div" : "mult", i, busy_cnt, stall);
        end
    endtask

    task automatic test_simultaneous();
        stim_t s;
        exp_t  e;
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            s = idle();
            if (i == 0) begin
                s.smul = 1'b1;
                s.sdiv = 1'b1;
                drive(s, mk(1'b0, 4'd0, 32'd0));
            end else if (i <= 8) begin
                if (i == 8) s.smul = 1'b1;
                drive(s, mk(1'b0, 4'(11 - i), 32'd0));
            end else begin
                drive(s, mk(1'b0, 4'(14 - i), 32'd0));
            end
            e = exp_q.pop_front();
            tests_run++;
            if ({busy, busy_cnt, stall} !== {e.cnt != 4'd0, e.cnt, e.stall}) begin
                tests_failed++;
                $display("FAIL simultaneous step %0d: busy=%0b cnt=%0d stall=%0b required cnt=%0d stall=%0b",
                         i, busy, busy_cnt, stall, e.cnt, e.stall);
            end else $display("[TB] simultaneous step %0d ok cnt=%0d", i, busy_cnt);
        end
    endtask

    task automatic test_reset_mid();
        stim_t s;
        exp_t  e;
        do_reset();
        for (int i = 0; i <= 4; i++) begin
            s = idle();
            s.md = (i != 0);
            s.sdiv = (i == 0);
            if (i == 0) drive(s, mk(1'b0, 4'd0, 32'd0));
            else        drive(s, mk(1'b1, 4'(11 - i), 32'(i - 1)));
            e = exp_q.pop_front();
            tests_run++;
            if ({stall, busy_cnt, stall_count} !== {e.stall, e.cnt, e.sc}) begin
                tests_failed++;
                $display("FAIL reset_mid step %0d: stall=%0b cnt=%0d sc=%0d required stall=%0b cnt=%0d sc=%0d",
                         i, stall, busy_cnt, stall_count, e.stall, e.cnt, e.sc);
            end else $display("[TB] reset_mid step %0d ok cnt=%0d", i, busy_cnt);
        end
        #1;
        start_div_ex = 1'b1;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({stall, flush_id_ex, busy, busy_cnt, stall_count} !== {1'b0, 1'b0, 1'b0, 4'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_mid_async: stall=%0b flush=%0b busy=%0b cnt=%0d sc=%0d required all 0",
                     stall, flush_id_ex, busy, busy_cnt, stall_count);
        end else $display("[TB] reset_mid_async ok");
        start_div_ex = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = idle();
            s.md = 1'b1;
            drive(s, mk(1'b0, 4'd0, 32'd0));
            e = exp_q.pop_front();
            tests_run++;
            if ({stall, busy, busy_cnt} !== {e.stall, 1'b0, e.cnt}) begin
                tests_failed++;
                $display("FAIL reset_mid_after step %0d: stall=%0b busy=%0b cnt=%0d required 0", i, stall, busy, busy_cnt);
            end else $display("[TB] reset_mid_after step %0d ok", i);
        end
    endtask

    task automatic test_stats();
        stim_t s;
        exp_t  e;
        do_reset();
        for (int i = 0; i <= 6; i++) begin
            s = load_ex(5'd8);
            s.use_rs = 1'b1;
            s.rs = 5'd8;
            case (i)
                0: drive(s, mk(1'b1, 4'd0, 32'd0));
                1, 2, 3: drive(s, mk(1'b1, 4'd0, 32'hFFFF_FFFF));
                4: begin s.clr = 1'b1; drive(s, mk(1'b1, 4'd0, 32'hFFFF_FFFF)); end
                5: drive(s, mk(1'b1, 4'd0, 32'd0));
                default: drive(idle(), mk(1'b0, 4'd0, 32'd1));
            endcase
            e = exp_q.pop_front();
            tests_run++;
            if ({stall, stall_count} !== {e.stall, e.sc}) begin
                tests_failed++;
                $display("FAIL stats step %0d: stall=%0b sc=%h required stall=%0b sc=%h",
                         i, stall, stall_count, e.stall, e.sc);
            end else $display("[TB] stats step %0d ok sc=%h", i, stall_count);
            if (i == 0) begin
                force dut.stall_count_reg = 32'hFFFF_FFFE;
                #1;
                release dut.stall_count_reg;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        apply(idle());
        #12;
        reset = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_md(1'b0);
        test_md(1'b1);
        test_simultaneous();
        test_reset_mid();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
